fetch_sequencer: RTL and testbench

//  Owns the architectural PC and sequences instruction fetch for the 5-stage pipeline.

---
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_fetch_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the architectural PC, issues single-cycle IM requests and buffers one
// fetched instruction (or a misaligned-fetch bubble) for the IF/ID stage.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  input  logic        i_exc_req,
  input  logic        i_eret_req,
  input  logic [31:0] i_epc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic        o_if_adel
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StErr   = 2'd2
  } state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic        r_if_valid, w_if_valid_d;
  logic [31:0] r_if_pc, w_if_pc_d;
  logic [31:0] r_if_instr, w_if_instr_d;
  logic        r_if_adel, w_if_adel_d;

  logic w_fire;
  logic w_slot_free;
  logic w_aligned;
  logic w_flush;
  logic w_accept;

  assign w_fire      = r_if_valid & ~i_stall;
  assign w_slot_free = ~r_if_valid | w_fire;
  assign w_aligned   = (r_pc[1:0] == 2'b00);
  assign w_flush     = i_exc_req | i_eret_req | i_redirect_valid;

  assign o_imem_req  = (r_state == StFetch) & w_slot_free & w_aligned;
  assign o_imem_addr = r_pc;

  // An ack arriving alongside any PC change belongs to the wrong path and is dropped.
  assign w_accept = o_imem_req & i_imem_ack & ~w_flush;

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_if_valid_d = r_if_valid & ~w_fire;
    w_if_pc_d    = r_if_pc;
    w_if_instr_d = r_if_instr;
    w_if_adel_d  = r_if_adel;

    unique case (r_state)
      StIdle: w_state_d = StFetch;
      StFetch: begin
        if (w_accept) begin
          w_if_valid_d = 1'b1;
          w_if_pc_d    = r_pc;
          w_if_instr_d = i_imem_rdata;
          w_if_adel_d  = 1'b0;
          w_pc_d       = r_pc + 32'd4;
        end else if (!w_aligned && w_slot_free && !w_flush) begin
          w_if_valid_d = 1'b1;
          w_if_pc_d    = r_pc;
          w_if_instr_d = 32'h0;
          w_if_adel_d  = 1'b1;
          w_state_d    = StErr;
        end
      end
      StErr: ;
      default: w_state_d = StIdle;
    endcase

    // Lowest priority first so later assignments win.
    if (i_redirect_valid) begin
      w_pc_d    = i_redirect_target;
      w_state_d = StFetch;
    end
    if (i_eret_req) begin
      w_pc_d       = i_epc;
      w_if_valid_d = 1'b0;
      w_state_d    = StFetch;
    end
    if (i_exc_req) begin
      w_pc_d       = EXC_VECTOR;
      w_if_valid_d = 1'b0;
      w_state_d    = StFetch;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= 32'h0;
      r_if_adel  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_if_valid <= w_if_valid_d;
      r_if_pc    <= w_if_pc_d;
      r_if_instr <= w_if_instr_d;
      r_if_adel  <= w_if_adel_d;
    end
  end

  assign o_if_valid = r_if_valid;
  assign o_if_pc    = r_if_pc;
  assign o_if_instr = r_if_instr;
  assign o_if_adel  = r_if_adel;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer; each row gives one cycle's inputs and the
// outputs expected during that cycle (before the closing clock edge).
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, exc_req, eret_req, imem_ack;
  logic [31:0] redirect_target, epc;
  logic        imem_req, if_valid, if_adel;
  logic [31:0] imem_addr, imem_rdata, if_pc, if_instr;

  // Instruction memory returns a word tagged with its own address.
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_target(redirect_target),
    .i_exc_req        (exc_req),
    .i_eret_req       (eret_req),
    .i_epc            (epc),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_ack       (imem_ack),
    .i_imem_rdata     (imem_rdata),
    .o_if_valid       (if_valid),
    .o_if_pc          (if_pc),
    .o_if_instr       (if_instr),
    .o_if_adel        (if_adel)
  );

  typedef struct {
    logic        rst, stl, rv;
    logic [31:0] tgt;
    logic        exc, eret;
    logic [31:0] epc;
    logic        ack, chk, req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc, instr;
    logic        adel;
  } vec_t;

  localparam int NV = 35;
  vec_t tv[NV];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic rst, stl, rv, input logic [31:0] tgt,
                              input logic exc, eret, input logic [31:0] ep, input logic ack,
                              input logic chk, req, input logic [31:0] addr, input logic v,
                              input logic [31:0] pc, instr, input logic adel);
    vec_t t;
    t.rst = rst; t.stl = stl; t.rv = rv; t.tgt = tgt; t.exc = exc; t.eret = eret; t.epc = ep;
    t.ack = ack; t.chk = chk; t.req = req; t.addr = addr; t.v = v; t.pc = pc;
    t.instr = instr; t.adel = adel;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic req, input logic [31:0] addr,
                            input logic v, input logic [31:0] pc, instr, input logic adel);
    check($sformatf("v%0d imem_req", idx), {31'b0, imem_req}, {31'b0, req});
    check($sformatf("v%0d imem_addr", idx), imem_addr, addr);
    check($sformatf("v%0d if_valid", idx), {31'b0, if_valid}, {31'b0, v});
    check($sformatf("v%0d if_pc", idx), if_pc, pc);
    check($sformatf("v%0d if_instr", idx), if_instr, instr);
    check($sformatf("v%0d if_adel", idx), {31'b0, if_adel}, {31'b0, adel});
  endtask

  task automatic drive(input vec_t t);
    reset = t.rst; stall = t.stl; redirect_valid = t.rv; redirect_target = t.tgt;
    exc_req = t.exc; eret_req = t.eret; epc = t.epc; imem_ack = t.ack;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0; imem_ack = 1'b0;

    //           rst s rv tgt           ex er epc       ak ck rq addr          v  if_pc         instr         adel
    tv[0]  = mk(1, 0, 0, 0,            0, 0, 0,        0, 0, 0, 0,            0, 0,            0,            0);
    tv[1]  = mk(1, 0, 0, 0,            0, 0, 0,        0, 1, 0, 32'h3000,     0, 0,            0,            0);
    tv[2]  = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 0, 32'h3000,     0, 0,            0,            0);
    tv[3]  = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'h3000,     0, 0,            0,            0);
    tv[4]  = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'h3004,     1, 32'h3000, 32'hC0DE3000, 0);
    tv[5]  = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'h3008,     1, 32'h3004, 32'hC0DE3004, 0);
    // IM wait states: request held at 0x300C, slot drains
    tv[6]  = mk(0, 0, 0, 0,            0, 0, 0,        0, 1, 1, 32'h300C,     1, 32'h3008, 32'hC0DE3008, 0);
    tv[7]  = mk(0, 0, 0, 0,            0, 0, 0,        0, 1, 1, 32'h300C,     0, 32'h3008, 32'hC0DE3008, 0);
    tv[8]  = mk(0, 0, 0, 0,            0, 0, 0,        0, 1, 1, 32'h300C,     0, 32'h3008, 32'hC0DE3008, 0);
    tv[9]  = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'h300C,     0, 32'h3008, 32'hC0DE3008, 0);
    // stall with slot full
    tv[10] = mk(0, 1, 0, 0,            0, 0, 0,        1, 1, 0, 32'h3010,     1, 32'h300C, 32'hC0DE300C, 0);
    tv[11] = mk(0, 1, 0, 0,            0, 0, 0,        1, 1, 0, 32'h3010,     1, 32'h300C, 32'hC0DE300C, 0);
    tv[12] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'h3010,     1, 32'h300C, 32'hC0DE300C, 0);
    // redirect: delay slot 0x3010 consumed, ack for 0x3014 dropped
    tv[13] = mk(0, 0, 1, 32'h3040,     0, 0, 0,        1, 1, 1, 32'h3014,     1, 32'h3010, 32'hC0DE3010, 0);
    tv[14] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'h3040,     0, 32'h3010, 32'hC0DE3010, 0);
    // exc beats redirect and clears slot under stall; then eret
    tv[15] = mk(0, 1, 1, 32'h3080,     1, 0, 0,        1, 1, 0, 32'h3044,     1, 32'h3040, 32'hC0DE3040, 0);
    tv[16] = mk(0, 0, 0, 0,            0, 1, 32'h3010, 1, 1, 1, 32'h4180,     0, 32'h3040, 32'hC0DE3040, 0);
    tv[17] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'h3010,     0, 32'h3040, 32'hC0DE3040, 0);
    // misaligned redirect -> AdEL bubble, ERR
    tv[18] = mk(0, 0, 1, 32'h3042,     0, 0, 0,        1, 1, 1, 32'h3014,     1, 32'h3010, 32'hC0DE3010, 0);
    tv[19] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 0, 32'h3042,     0, 32'h3010, 32'hC0DE3010, 0);
    tv[20] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 0, 32'h3042,     1, 32'h3042, 32'h0,        1);
    tv[21] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 0, 32'h3042,     0, 32'h3042, 32'h0,        1);
    tv[22] = mk(0, 0, 0, 0,            1, 0, 0,        1, 1, 0, 32'h3042,     0, 32'h3042, 32'h0,        1);
    tv[23] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'h4180,     0, 32'h3042, 32'h0,        1);
    tv[24] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'h4184,     1, 32'h4180, 32'hC0DE4180, 0);
    // back into ERR, then reset mid-ERR
    tv[25] = mk(0, 0, 1, 32'h3001,     0, 0, 0,        1, 1, 1, 32'h4188,     1, 32'h4184, 32'hC0DE4184, 0);
    tv[26] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 0, 32'h3001,     0, 32'h4184, 32'hC0DE4184, 0);
    tv[27] = mk(0, 1, 0, 0,            0, 0, 0,        1, 1, 0, 32'h3001,     1, 32'h3001, 32'h0,        1);
    tv[28] = mk(1, 1, 0, 0,            0, 0, 0,        1, 1, 0, 32'h3001,     1, 32'h3001, 32'h0,        1);
    tv[29] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 0, 32'h3000,     0, 0,            0,            0);
    tv[30] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'h3000,     0, 0,            0,            0);
    // PC wrap at the top of the address space
    tv[31] = mk(0, 0, 1, 32'hFFFFFFFC, 0, 0, 0,        1, 1, 1, 32'h3004,     1, 32'h3000, 32'hC0DE3000, 0);
    tv[32] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'hFFFFFFFC, 0, 32'h3000, 32'hC0DE3000, 0);
    tv[33] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'h0,        1, 32'hFFFFFFFC, 32'hC0DEFFFC, 0);
    tv[34] = mk(0, 0, 0, 0,            0, 0, 0,        1, 1, 1, 32'h4,        1, 32'h0,     32'hC0DE0000, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      if (tv[i].chk) begin
        n_vec++;
        check_outs(i, tv[i].req, tv[i].addr, tv[i].v, tv[i].pc, tv[i].instr, tv[i].adel);
      end
      if (tv[i].rv && !tv[i].exc && !tv[i].eret && !(if_valid && !stall)) begin
        n_fail++;
        $display("FAIL v%0d delay-slot contract: if_valid=%b stall=%b, required 1/0", i,
                 if_valid, stall);
      end
    end

    // eret under stall flushes a full slot; ack in that cycle is dropped.
    @(negedge clk);
    stall = 1'b1; eret_req = 1'b1; epc = 32'h3020; imem_ack = 1'b1;
    #1;
    n_vec++;
    check_outs(100, 1'b0, 32'h8, 1'b1, 32'h4, 32'hC0DE0004, 1'b0);
    @(negedge clk);
    stall = 1'b0; eret_req = 1'b0;
    #1;
    n_vec++;
    check_outs(101, 1'b1, 32'h3020, 1'b0, 32'h4, 32'hC0DE0004, 1'b0);
    @(negedge clk);
    #1;
    n_vec++;
    check_outs(102, 1'b1, 32'h3024, 1'b1, 32'h3020, 32'hC0DE3020, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
